// File: rtl/mips_cpu_hilo_if.sv
// -----------------------------------------------------------------------------
// mips_cpu_hilo_if
//   Signal bundle between the pipeline (master) and the HI/LO unit (slave).
//
//   Request/accept rule: start, wr_hi and wr_lo are accepted on any rising
//   edge where busy is low. While busy is high every request is dropped and
//   stall is raised for as long as the request is held. The requester keeps
//   the instruction and retries until stall falls. rd_hi/rd_lo are
//   combinational reads that never change unit state.
//
//   Master drives : start, op, data_1, data_2, wr_hi, wr_lo, wr_hi_data,
//                   wr_lo_data, rd_hi, rd_lo
//   Slave drives  : hi, lo, rd_data, busy, stall
// -----------------------------------------------------------------------------
interface mips_cpu_hilo_if;
    logic        start;
    logic [1:0]  op;          // 00 mult, 01 multu, 10 div, 11 divu
    logic [31:0] data_1;      // rs: multiplicand / dividend
    logic [31:0] data_2;      // rt: multiplier / divisor
    logic        wr_hi;       // mthi
    logic        wr_lo;       // mtlo
    logic [31:0] wr_hi_data;
    logic [31:0] wr_lo_data;
    logic        rd_hi;       // mfhi
    logic        rd_lo;       // mflo
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;

    modport master (
        output start, op, data_1, data_2, wr_hi, wr_lo, wr_hi_data,
               wr_lo_data, rd_hi, rd_lo,
        input  hi, lo, rd_data, busy, stall
    );

    modport slave (
        input  start, op, data_1, data_2, wr_hi, wr_lo, wr_hi_data,
               wr_lo_data, rd_hi, rd_lo,
        output hi, lo, rd_data, busy, stall
    );
endinterface

// File: rtl/mips_cpu_hilo.sv
// -----------------------------------------------------------------------------
// mips_cpu_hilo
//   Architectural HI/LO registers plus a 32-iteration sequential engine for
//   mult/multu (shift-add) and div/divu (restoring divide). Serves mthi/mtlo
//   writes and mfhi/mflo reads, and stalls the pipeline while busy.
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     bus          mips_cpu_hilo_if.slave request/result bundle
//     dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
//   Timing: start taken at E0, iterations at E1..E32, FIX writes HI/LO at
//   E33, next start accepted at E34.
// -----------------------------------------------------------------------------
module mips_cpu_hilo (
    input  logic                  clk,
    input  logic                  reset,
    mips_cpu_hilo_if.slave        bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier bits still to consume}.
    // Divide:   {partial remainder, dividend bits becoming quotient bits}.
    logic [63:0] w_q, w_d;
    logic [31:0] m_q, m_d;        // |multiplicand| or |divisor|
    logic        div_q, div_d;    // operation is a divide
    logic        neg_q, neg_d;    // negate product / quotient
    logic        rneg_q, rneg_d;  // negate remainder (dividend negative)
    logic        dz_q, dz_d;      // divide by zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand conditioning at launch
    logic        op_signed;
    logic        op_div;
    logic [31:0] abs_1;
    logic [31:0] abs_2;

    assign op_signed = ~bus.op[0];
    assign op_div    = bus.op[1];
    assign abs_1     = (op_signed && bus.data_1[31]) ? (32'd0 - bus.data_1) : bus.data_1;
    assign abs_2     = (op_signed && bus.data_2[31]) ? (32'd0 - bus.data_2) : bus.data_2;

    // One shift-add step: add multiplicand when the next multiplier bit is
    // set, then shift the whole register right. The carry lands in bit 63.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = w_q[0] ? ({1'b0, w_q[63:32]} + {1'b0, m_q}) : {1'b0, w_q[63:32]};
    assign mul_next = {mul_sum, w_q[31:1]};

    // One restoring step: shift the next dividend bit into the remainder and
    // try subtracting the divisor. The remainder always stays below the
    // divisor, so 33 bits hold the shifted trial without loss.
    logic [32:0] div_trial;
    logic [63:0] div_next;

    assign div_trial = w_q[63:31] - {1'b0, m_q};
    assign div_next  = div_trial[32] ? {w_q[62:0], 1'b0}
                                     : {div_trial[31:0], w_q[30:0], 1'b1};

    // Fixup values used in FIX
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign prod_fix = neg_q  ? (64'd0 - w_q) : w_q;
    assign quo_fix  = dz_q   ? 32'hFFFF_FFFF
                             : (neg_q ? (32'd0 - w_q[31:0]) : w_q[31:0]);
    // With a zero divisor the remainder path returns |data_1|; restoring the
    // dividend sign gives data_1 back unchanged, which is what HI must hold.
    assign rem_fix  = rneg_q ? (32'd0 - w_q[63:32]) : w_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        m_d     = m_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.wr_hi) hi_d = bus.wr_hi_data;
                if (bus.wr_lo) lo_d = bus.wr_lo_data;
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd31;
                    div_d   = op_div;
                    neg_d   = op_signed && (bus.data_1[31] ^ bus.data_2[31]);
                    rneg_d  = op_signed && op_div && bus.data_1[31];
                    dz_d    = op_div && (bus.data_2 == 32'd0);
                    if (op_div) begin
                        w_d = {32'd0, abs_1};
                        m_d = abs_2;
                    end else begin
                        w_d = {32'd0, abs_2};
                        m_d = abs_1;
                    end
                end
            end

            S_RUN: begin
                w_d = div_q ? div_next : mul_next;
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            w_q     <= 64'd0;
            m_q     <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            m_q     <= m_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.stall   = bus.busy & (bus.start | bus.wr_hi | bus.wr_lo | bus.rd_hi | bus.rd_lo);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    // Reads are never blocked here; while busy they return the old value and
    // the stall keeps the pipeline from consuming it.
    assign bus.rd_data = bus.rd_hi ? hi_q : (bus.rd_lo ? lo_q : 32'd0);
    assign dbg_state_o = state_q;

endmodule

// File: doc/mips_cpu_hilo.md
# mips_cpu_hilo

Sequential HI/LO unit sitting directly downstream of the MIPS ALU. It owns the architectural HI and LO registers and accepts direct writes for mthi/mtlo, using the ALU's `r`/`r_lo` and `hi_en`/`lo_en`. It runs mult/multu/div/divu as a 32-iteration shift-add / restoring-divide engine instead of single-cycle combinational operators. It serves mfhi/mflo reads and raises a stall to the pipeline while an operation is in flight.

## Interface
Parameters:
- No parameters. The datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch the operation selected by `op`.
- `op`  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- `data_1`  in  32  rs operand (multiplicand / dividend).
- `data_2`  in  32  rt operand (multiplier / divisor).
- `wr_hi`  in  1  direct HI write (mthi), driven from the ALU's `hi_en`.
- `wr_lo`  in  1  direct LO write (mtlo), driven from the ALU's `lo_en`.
- `wr_hi_data`  in  32  HI write data, driven from the ALU's `r`.
- `wr_lo_data`  in  32  LO write data, driven from the ALU's `r_lo`.
- `rd_hi`  in  1  mfhi request.
- `rd_lo`  in  1  mflo request.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.
- `rd_data`  out  32  read mux output.
- `busy`  out  1  operation in flight.
- `stall`  out  1  pipeline must hold the current instruction.

## Operation
- **FSM states:** IDLE, RUN, FIX.
  - In IDLE, `start`=1 → RUN. The unit latches |data_1|, |data_2| (absolute values only for signed ops), result-sign flags and the op, and loads iteration counter = 31.
  - In RUN, one iteration is performed per cycle. When the counter reaches 0 → FIX.
  - FIX applies the sign fixup, writes HI/LO, then returns to IDLE.
- **Multiply:** 64-bit shift-add, one multiplier bit per iteration. For signed ops, the 64-bit product is negated if the operand signs differ. HI = product[63:32], LO = product[31:0].
- **Divide:** restoring division, one quotient bit per iteration. For signed ops:
  - the quotient is negated if the operand signs differ;
  - the remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- **Divide by zero** (signed or unsigned): LO = 0xFFFFFFFF, HI = data_1 as latched. No sign fixup is applied.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Direct writes:** honoured only in IDLE. `wr_hi` and `wr_lo` are independent and may be asserted in the same cycle.
- **`start` together with `wr_hi`/`wr_lo` in IDLE:** the direct write lands this edge. The operation result later overwrites both HI and LO.
- **Requests while busy:** `start`, `wr_hi` and `wr_lo` are ignored (the requester is stalled).
- **`rd_data`:**
  - `rd_hi` ? `hi` : `rd_lo` ? `lo` : 0.
  - HI has priority if both requests are high.
  - Combinational, and it shows the current register contents even while busy (stale).
- **`stall`** = `busy` & (`start` | `wr_hi` | `wr_lo` | `rd_hi` | `rd_lo`), combinational.
- **`busy`** is high in RUN and FIX.
- **Reset** (async, including mid-operation): HI = 0, LO = 0, state = IDLE, `busy` = 0, `stall` = 0, `rd_data` = 0 with no reads requested. Any operation in progress is discarded.

## Timing
- `start` sampled at edge E0 → `busy` is high from after E0 through E33 (33 cycles: E1..E32 are iterations, E33 is FIX).
- HI/LO take the new result after E33, so an mfhi/mflo issued in the cycle after E33 reads it with no stall.
- A new `start` is accepted at E34 at the earliest, i.e. back-to-back throughput is 34 cycles per operation.
- Direct writes: a value written at edge E is visible on `hi`/`lo`/`rd_data` in the cycle after E.
- The operand inputs are not required to stay stable after E0.

## Test plan
- **multu:** 0xFFFFFFFF × 0xFFFFFFFF, start at E0 → `busy` for 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001 after E33.
- **mult:** −3 (0xFFFFFFFD) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Also 0x80000000 / 0xFFFFFFFF via div → LO = 0x80000000, HI = 0.
- **div:** −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **divu:** 0x12345678 / 0x10 → LO = 0x01234567, HI = 0x8.
- **divu by zero:** 100 / 0 → LO = 0xFFFFFFFF, HI = 100.
- **Hazards while busy:** `rd_hi` during a mult → `stall` = 1 each cycle until `busy` falls, then `rd_data` = new HI.
- **Writes while busy:** `wr_lo` = 1 with data 0xAA while busy → ignored, `stall` = 1. The same write in IDLE → LO = 0xAA the next cycle.
- **Reset mid-operation:** assert `reset` 10 cycles into a div → HI = LO = 0 and `busy` = 0 immediately. A subsequent multu 6 × 7 → LO = 42, HI = 0.
